// File: rtl/word_splitter_seq_pkg.sv
// Shared definitions for the sequential word splitter: FSM encoding,
// chunk-order mode constants and the index-width helper.
package word_splitter_seq_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic MODE_LSB = 1'b0;
  localparam logic MODE_MSB = 1'b1;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/word_splitter_seq.sv
// Accepts one WIDTH-bit word over valid/ready and emits it as WIDTH/LANE
// chunks, MSB-first or LSB-first as selected per word.
module word_splitter_seq
  import word_splitter_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  localparam int N    = WIDTH / LANE,
  localparam int IW   = (clog2(N) > 1) ? clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANE-1:0]  out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output state_t           dbg_state
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if (N < 2 || (WIDTH % LANE) != 0) begin : g_bad_params
    $error("word_splitter_seq: WIDTH must be a multiple of LANE with at least 2 chunks");
  end

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; valid never depends on ready, and a presented chunk
  // holds stable until it is taken.
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [IW-1:0]    cnt;
  logic             mode;
  logic             in_accept;
  logic             out_accept;

  assign out_valid  = (state == S_SEND);
  assign out_last   = (state == S_SEND) && (cnt == LAST_IDX);
  assign out_idx    = cnt;
  assign out_data   = (mode == MODE_MSB) ? sr[WIDTH-1 -: LANE] : sr[LANE-1:0];
  assign dbg_state  = state;

  // Ready while idle, or on the final beat being taken: zero-bubble reload.
  assign in_ready   = (state == S_IDLE) || (out_last && out_ready);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      mode  <= MODE_MSB;
    end else if (in_accept) begin
      state <= S_SEND;
      sr    <= in_data;
      mode  <= in_msb_first;
      cnt   <= '0;
    end else if (out_accept) begin
      if (cnt == LAST_IDX) begin
        state <= S_IDLE;
      end else begin
        sr  <= (mode == MODE_MSB) ? (sr << LANE) : (sr >> LANE);
        cnt <= cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_splitter_seq.sv
// Directed table-driven bench for word_splitter_seq (32/8 instance) plus a
// 16/4 instance for the parameter sweep.
module tb_word_splitter_seq;
  import word_splitter_seq_pkg::*;

  logic clk;
  logic reset;

  logic        in_valid, in_ready, in_msb_first, out_valid, out_ready, out_last;
  logic [31:0] in_data;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  state_t      dbg_state;

  logic        in_valid16, in_ready16, in_msb16, out_valid16, out_ready16, out_last16;
  logic [15:0] in_data16;
  logic [3:0]  out_data16;
  logic [1:0]  out_idx16;
  state_t      dbg_state16;

  int n_checks = 0;
  int n_fail   = 0;

  word_splitter_seq #(.WIDTH(32), .LANE(8)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_msb_first(in_msb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .dbg_state(dbg_state)
  );

  word_splitter_seq #(.WIDTH(16), .LANE(4)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .in_msb_first(in_msb16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
    .out_idx(out_idx16), .out_last(out_last16), .dbg_state(dbg_state16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_msb;
    logic        out_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_idx;
    logic        exp_last;
    logic        exp_in_ready;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] d, input logic msb, input logic ordy,
                     input logic ev, input logic [7:0] ed, input logic [1:0] ei,
                     input logic el, input logic eir);
    vec_t v;
    v.in_valid = iv;  v.in_data = d;   v.in_msb = msb;  v.out_ready = ordy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_idx = ei; v.exp_last = el;
    v.exp_in_ready = eir;
    vecs.push_back(v);
  endtask

  // Driver: called at posedge+1; drives one cycle, checks mid-cycle, advances.
  task automatic apply_vec(input vec_t v, input string tag);
    in_valid     = v.in_valid;
    in_data      = v.in_data;
    in_msb_first = v.in_msb;
    out_ready    = v.out_ready;
    #4;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_valid));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_in_ready));
    chk({tag, " out_last"}, 32'(out_last), 32'(v.exp_last));
    chk({tag, " state"}, 32'(dbg_state == S_SEND), 32'(v.exp_valid));
    if (v.exp_valid) begin
      chk({tag, " out_data"}, 32'(out_data), 32'(v.exp_data));
      chk({tag, " out_idx"}, 32'(out_idx), 32'(v.exp_idx));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++)
      apply_vec(vecs[i], $sformatf("%s[%0d]", name, i));
    vecs.delete();
  endtask

  initial begin
    logic [15:0] w16;
    reset = 1'b1;
    in_valid = 0; in_data = '0; in_msb_first = 0; out_ready = 0;
    in_valid16 = 0; in_data16 = '0; in_msb16 = 0; out_ready16 = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_idx", 32'(out_idx), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // MSB-first, then LSB-first of the same word (accept in the idle cycle)
    add(1, 32'hF1A5A077, 1, 1,  0, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'hF1, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hA5, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hA0, 2, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h77, 3, 1, 1);
    add(1, 32'hF1A5A077, 0, 1,  0, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'h77, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hA0, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hA5, 2, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hF1, 3, 1, 1);
    // Back-pressure: beat 1 held for 3 cycles; completes 7 edges after accept
    add(1, 32'hF1A5A077, 1, 1,  0, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'hF1, 0, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hA5, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hA0, 2, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h77, 3, 1, 1);
    // Back-to-back with in_valid held high; next word waits until last beat
    add(1, 32'h01234567, 1, 1,  0, 8'h00, 0, 0, 1);
    add(1, 32'h89ABCDEF, 0, 1,  1, 8'h01, 0, 0, 0);
    add(1, 32'h89ABCDEF, 0, 1,  1, 8'h23, 1, 0, 0);
    add(1, 32'h89ABCDEF, 0, 1,  1, 8'h45, 2, 0, 0);
    add(1, 32'h89ABCDEF, 0, 1,  1, 8'h67, 3, 1, 1);
    add(0, 32'h0,        0, 1,  1, 8'hEF, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hCD, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hAB, 2, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h89, 3, 1, 1);
    // Stalled last beat blocks the reload until out_ready returns
    add(1, 32'h12345678, 1, 1,  0, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'h12, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h34, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h56, 2, 0, 0);
    add(1, 32'hCAFEF00D, 0, 0,  1, 8'h78, 3, 1, 0);
    add(1, 32'hCAFEF00D, 0, 1,  1, 8'h78, 3, 1, 1);
    add(0, 32'h0,        0, 1,  1, 8'h0D, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hF0, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hFE, 2, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hCA, 3, 1, 1);
    add(0, 32'h0,        0, 1,  0, 8'h00, 0, 0, 1);
    run_table("main");

    // Reset mid-word, after beat 1 of DEADBEEF has been taken
    add(1, 32'hDEADBEEF, 1, 1,  0, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'hDE, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hAD, 1, 0, 0);
    run_table("pre_reset");
    reset = 1'b1;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_data", 32'(out_data), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset out_idx", 32'(out_idx), 32'd0);
    chk("midreset out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    add(1, 32'h00000011, 0, 1,  0, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'h11, 0, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h00, 1, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h00, 2, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h00, 3, 1, 1);
    add(0, 32'h0,        0, 1,  0, 8'h00, 0, 0, 1);
    run_table("post_reset");

    // Parameter sweep: 16-bit word in 4-bit lanes, MSB-first
    w16 = 16'hABCD;
    for (int i = 3; i >= 0; i--) exp_q.push_back(w16[i*4 +: 4]);
    in_valid16 = 1; in_data16 = w16; in_msb16 = 1; out_ready16 = 1;
    #4;
    chk("p16 accept in_ready", 32'(in_ready16), 32'd1);
    chk("p16 accept out_valid", 32'(out_valid16), 32'd0);
    @(posedge clk);
    #1;
    in_valid16 = 0; in_data16 = 16'h0000;
    for (int b = 0; b < 4; b++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      #4;
      chk($sformatf("p16[%0d] out_valid", b), 32'(out_valid16), 32'd1);
      chk($sformatf("p16[%0d] out_data", b), 32'(out_data16), 32'(e));
      chk($sformatf("p16[%0d] out_idx", b), 32'(out_idx16), 32'(b));
      chk($sformatf("p16[%0d] out_last", b), 32'(out_last16), 32'(b == 3));
      @(posedge clk);
      #1;
    end
    #4;
    chk("p16 idle out_valid", 32'(out_valid16), 32'd0);
    chk("p16 idle in_ready", 32'(in_ready16), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
